// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the test-status device: register offsets, FSM states
// and the TOHOST value that reports a passing run.
package sim_ctrl_pkg;

  localparam logic [1:0] OFF_TOHOST  = 2'd0;
  localparam logic [1:0] OFF_CONSOLE = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;
  localparam logic [1:0] OFF_INSTRET = 2'd3;

  localparam logic [31:0] TOHOST_PASS = 32'd1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/test_status_mmio_if.sv
// Bus bundle between the CPU side (MEM/WB stages, console consumer) and the
// test-status device.
interface test_status_mmio_if;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] pc_WB;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [30:0] fail_code;

  modport master (
    output mem_we, mem_re, mem_addr, mem_wdata, wb_valid, pc_WB, con_ready,
    input  mem_rdata, con_valid, con_data, done, pass, timeout, fail_code
  );

  modport slave (
    input  mem_we, mem_re, mem_addr, mem_wdata, wb_valid, pc_WB, con_ready,
    output mem_rdata, con_valid, con_data, done, pass, timeout, fail_code
  );
endinterface

// File: rtl/console_fifo.sv
// Synchronous FIFO for console bytes; a push into a full FIFO is still accepted
// when a pop happens in the same cycle. DEPTH must be a power of two >= 2.
module console_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Stale storage is hidden so the output reads zero whenever nothing is buffered.
  assign pop_data = empty ? '0 : storage[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/test_status_mmio.sv
// Memory-mapped test-status device: TOHOST/console/counter register window,
// halt-PC watch and a sticky done/pass/timeout verdict for the bench to poll.
module test_status_mmio
  import sim_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_1000,
  parameter logic [31:0] HALT_PC    = 32'h8000_0078,
  parameter int          TIMEOUT    = 100000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rstn,
  test_status_mmio_if.slave bus
);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam bit          TIMEOUT_ON   = (TIMEOUT != 0);

  state_t      state;
  state_t      state_next;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic [31:0] rd_value;
  logic [31:0] rdata_q;
  logic        overflow;
  logic        pass_q;
  logic        timeout_q;
  logic [30:0] fail_code_q;
  logic        in_win;
  logic        running;
  logic [1:0]  offset;
  logic        tohost_term;
  logic        halt_hit;
  logic        timeout_hit;
  logic        terminate;
  logic        con_write;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        unused_addr_bits;

  assign in_win           = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset           = bus.mem_addr[3:2];
  assign unused_addr_bits = ^bus.mem_addr[1:0];
  assign running          = (state == ST_RUN);

  // Terminate sources; priority among them only matters for the latched verdict.
  assign tohost_term = running && bus.mem_we && in_win && (offset == OFF_TOHOST) && bus.mem_wdata[0];
  assign halt_hit    = running && bus.wb_valid && (bus.pc_WB == HALT_PC);
  assign timeout_hit = running && TIMEOUT_ON && (cycle_cnt == TIMEOUT_LAST);
  assign terminate   = tohost_term || halt_hit || timeout_hit;

  assign con_write = running && bus.mem_we && in_win && (offset == OFF_CONSOLE);
  assign fifo_pop  = !fifo_empty && bus.con_ready;

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_console_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (con_write),
    .push_data (bus.mem_wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rstn) state <= ST_RUN;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (terminate) state_next = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_comb begin
    bus.done      = (state == ST_HALTED);
    bus.con_valid = !fifo_empty;
    bus.con_data  = fifo_data;
    bus.mem_rdata = rdata_q;
    bus.pass      = pass_q;
    bus.timeout   = timeout_q;
    bus.fail_code = fail_code_q;
  end

  always_comb begin
    rd_value = 32'd0;
    if (in_win) begin
      case (offset)
        OFF_CYCLE:   rd_value = cycle_cnt;
        OFF_INSTRET: rd_value = instret_cnt;
        default:     rd_value = {30'd0, overflow, bus.done};
      endcase
    end
  end

  // Counters freeze on the terminating edge itself, so CYCLE reports the cycle of the event.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
      overflow    <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= 31'd0;
      rdata_q     <= 32'd0;
    end else begin
      if (running && !terminate) begin
        cycle_cnt <= cycle_cnt + 32'd1;
        if (bus.wb_valid) instret_cnt <= instret_cnt + 32'd1;
      end
      if (tohost_term) begin
        pass_q      <= (bus.mem_wdata == TOHOST_PASS);
        fail_code_q <= (bus.mem_wdata == TOHOST_PASS) ? 31'd0 : bus.mem_wdata[31:1];
      end else if (halt_hit) begin
        pass_q <= 1'b1;
      end else if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
      if (con_write && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (bus.mem_re) rdata_q <= rd_value;
    end
  end

endmodule

// File: tb/tb_test_status_mmio.sv
// Bench for test_status_mmio: table-driven console/drain sequence, hand-written
// verdict sequences, and randomized traffic checked against a behavioural model.
module tb_test_status_mmio;

  localparam logic [31:0] BASE  = 32'h8000_1000;
  localparam logic [31:0] HALT  = 32'h8000_0078;
  localparam int          TMO   = 50;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;

  test_status_mmio_if bus ();

  test_status_mmio #(
    .BASE_ADDR  (BASE),
    .HALT_PC    (HALT),
    .TIMEOUT    (TMO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wbv;
    logic [31:0] pc;
    bit          rdy;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          done;
    bit          pass;
    bit          con_valid;
    logic [7:0]  con_data;
    logic [31:0] rdata;
  } vec_t;

  // Behavioural model: a run is "terminated" after its first event, "halted"
  // once the byte queue is seen empty afterwards.
  bit          m_term, m_halt, m_over, m_pass, m_tmo;
  logic [30:0] m_fc;
  int unsigned m_cycle, m_instret;
  logic [31:0] m_rdata;
  logic [7:0]  m_q[$];

  function automatic void model_step(input stim_t s);
    bit win, running, popped, th, hp, tm;
    int off, size_before;
    if (s.rst) begin
      m_term = 0; m_halt = 0; m_over = 0; m_pass = 0; m_tmo = 0;
      m_fc = '0; m_cycle = 0; m_instret = 0; m_rdata = '0;
      m_q.delete();
      return;
    end
    win         = (s.addr >= BASE) && (s.addr < BASE + 32'd16);
    off         = win ? int'((s.addr - BASE) >> 2) : -1;
    running     = !m_term;
    size_before = m_q.size();
    popped      = (size_before > 0) && s.rdy;
    th = running && s.we && (off == 0) && s.wdata[0];
    hp = running && s.wbv && (s.pc == HALT);
    tm = running && (m_cycle == TMO - 1);
    if (s.re) begin
      if (off == 2)      m_rdata = m_cycle;
      else if (off == 3) m_rdata = m_instret;
      else if (win)      m_rdata = {30'd0, m_over, m_halt};
      else               m_rdata = 32'd0;
    end
    if (m_term && !m_halt && size_before == 0) m_halt = 1;
    if (popped) void'(m_q.pop_front());
    if (running && s.we && off == 1) begin
      if (size_before < DEPTH || popped) m_q.push_back(s.wdata[7:0]);
      else m_over = 1;
    end
    if (th) begin
      m_term = 1;
      m_pass = (s.wdata == 32'd1);
      m_fc   = m_pass ? 31'd0 : s.wdata[31:1];
    end else if (hp) begin
      m_term = 1;
      m_pass = 1;
    end else if (tm) begin
      m_term = 1;
      m_tmo  = 1;
    end else if (running) begin
      m_cycle++;
      if (s.wbv) m_instret++;
    end
  endfunction

  function automatic logic [79:0] model_vec();
    logic [7:0] cd;
    cd = (m_q.size() > 0) ? m_q[0] : 8'd0;
    return {5'd0, m_halt, m_pass, m_tmo, m_fc, (m_q.size() > 0), cd, m_rdata};
  endfunction

  function automatic logic [79:0] dut_vec();
    return {5'd0, bus.done, bus.pass, bus.timeout, bus.fail_code,
            bus.con_valid, bus.con_data, bus.mem_rdata};
  endfunction

  function automatic stim_t st_idle(input bit rdy);
    stim_t s;
    s.rst = 0; s.we = 0; s.re = 0; s.addr = '0; s.wdata = '0;
    s.wbv = 0; s.pc = '0; s.rdy = rdy;
    return s;
  endfunction

  function automatic stim_t st_rst();
    stim_t s;
    s = st_idle(0);
    s.rst = 1;
    return s;
  endfunction

  function automatic stim_t st_wr(input logic [31:0] addr, input logic [31:0] data, input bit rdy);
    stim_t s;
    s = st_idle(rdy);
    s.we = 1; s.addr = addr; s.wdata = data;
    return s;
  endfunction

  function automatic stim_t st_rd(input logic [31:0] addr, input bit rdy);
    stim_t s;
    s = st_idle(rdy);
    s.re = 1; s.addr = addr;
    return s;
  endfunction

  function automatic vec_t mk(input stim_t s, input bit done, input bit pass,
                              input bit cv, input logic [7:0] cd, input logic [31:0] rd);
    vec_t v;
    v.s = s; v.done = done; v.pass = pass; v.con_valid = cv; v.con_data = cd; v.rdata = rd;
    return v;
  endfunction

  // Called just after a falling edge; returns at the next falling edge.
  task automatic apply_stimulus(input stim_t s);
    rstn          = s.rst;
    bus.mem_we    = s.we;
    bus.mem_re    = s.re;
    bus.mem_addr  = s.addr;
    bus.mem_wdata = s.wdata;
    bus.wb_valid  = s.wbv;
    bus.pc_WB     = s.pc;
    bus.con_ready = s.rdy;
    model_step(s);
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_verdict(input string name, input bit done, input bit pass,
                               input bit tmo, input logic [30:0] fc);
    check_output(name, {46'd0, bus.done, bus.pass, bus.timeout, bus.fail_code},
                       {46'd0, done, pass, tmo, fc});
  endtask

  vec_t tbl[16];

  initial begin
    stim_t s;
    int    retired;

    apply_stimulus(st_rst());
    check_output("reset_state", dut_vec(), 80'd0);

    // Console overflow, drain under back-pressure, then halt.
    tbl[0]  = mk(st_wr(BASE + 4, 32'h41, 0), 0, 0, 1, 8'h41, 32'd0);
    tbl[1]  = mk(st_wr(BASE + 4, 32'h42, 0), 0, 0, 1, 8'h41, 32'd0);
    tbl[2]  = mk(st_wr(BASE + 4, 32'h43, 0), 0, 0, 1, 8'h41, 32'd0);
    tbl[3]  = mk(st_wr(BASE + 4, 32'h44, 0), 0, 0, 1, 8'h41, 32'd0);
    tbl[4]  = mk(st_wr(BASE + 4, 32'h45, 0), 0, 0, 1, 8'h41, 32'd0);
    tbl[5]  = mk(st_rd(BASE, 0),             0, 0, 1, 8'h41, 32'd2);
    tbl[6]  = mk(st_wr(BASE, 32'd1, 0),      0, 1, 1, 8'h41, 32'd2);
    tbl[7]  = mk(st_idle(0),                 0, 1, 1, 8'h41, 32'd2);
    tbl[8]  = mk(st_idle(1),                 0, 1, 1, 8'h42, 32'd2);
    tbl[9]  = mk(st_idle(1),                 0, 1, 1, 8'h43, 32'd2);
    tbl[10] = mk(st_idle(1),                 0, 1, 1, 8'h44, 32'd2);
    tbl[11] = mk(st_idle(1),                 0, 1, 0, 8'h00, 32'd2);
    tbl[12] = mk(st_idle(1),                 1, 1, 0, 8'h00, 32'd2);
    tbl[13] = mk(st_rd(BASE, 1),             1, 1, 0, 8'h00, 32'd3);
    tbl[14] = mk(st_rd(BASE + 8, 1),         1, 1, 0, 8'h00, 32'd6);
    tbl[15] = mk(st_wr(BASE + 4, 32'h5a, 1), 1, 1, 0, 8'h00, 32'd6);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(tbl[i].s);
      check_output($sformatf("table_row_%0d", i),
                   {37'd0, bus.done, bus.pass, bus.con_valid, bus.con_data, bus.mem_rdata},
                   {37'd0, tbl[i].done, tbl[i].pass, tbl[i].con_valid, tbl[i].con_data, tbl[i].rdata});
    end

    // TOHOST pass at cycle 20.
    apply_stimulus(st_rst());
    repeat (20) apply_stimulus(st_idle(0));
    apply_stimulus(st_wr(BASE, 32'd1, 0));
    check_verdict("pass_drain_not_done", 0, 1, 0, 31'd0);
    apply_stimulus(st_idle(0));
    check_verdict("pass_done", 1, 1, 0, 31'd0);
    apply_stimulus(st_rd(BASE + 8, 0));
    check_output("pass_cycle_read", {48'd0, bus.mem_rdata}, {48'd0, 32'd20});
    apply_stimulus(st_rd(BASE + 12, 0));
    check_output("pass_instret_read", {48'd0, bus.mem_rdata}, 80'd0);

    // Failing TOHOST value; a later pass write must not change the verdict.
    apply_stimulus(st_rst());
    apply_stimulus(st_wr(BASE, 32'd7, 0));
    apply_stimulus(st_idle(0));
    check_verdict("fail7_verdict", 1, 0, 0, 31'd3);
    apply_stimulus(st_wr(BASE, 32'd1, 0));
    apply_stimulus(st_idle(0));
    check_verdict("fail7_sticky", 1, 0, 0, 31'd3);

    // TOHOST and halt-PC retire in the same cycle: TOHOST wins.
    apply_stimulus(st_rst());
    s = st_wr(BASE, 32'd5, 0);
    s.wbv = 1; s.pc = HALT;
    apply_stimulus(s);
    apply_stimulus(st_idle(0));
    check_verdict("priority_tohost", 1, 0, 0, 31'd2);

    // Halt-PC retire on its own.
    apply_stimulus(st_rst());
    s = st_idle(0); s.wbv = 1; s.pc = 32'h8000_0070;
    apply_stimulus(s);
    s.pc = HALT;
    apply_stimulus(s);
    apply_stimulus(st_idle(0));
    check_verdict("halt_pc_pass", 1, 1, 0, 31'd0);

    // Timeout after 50 cycles with no terminate event.
    apply_stimulus(st_rst());
    retired = 0;
    for (int i = 0; i < TMO; i++) begin
      if (i == TMO - 1) check_verdict("timeout_not_yet", 0, 0, 0, 31'd0);
      s = st_idle(0);
      if (i < 40 && ($urandom % 2) == 1) begin
        s.wbv = 1;
        s.pc  = 32'h0000_1000 + 32'(i * 4);
        retired++;
      end
      apply_stimulus(s);
    end
    check_verdict("timeout_drain", 0, 0, 1, 31'd0);
    apply_stimulus(st_idle(0));
    check_verdict("timeout_done", 1, 0, 1, 31'd0);
    apply_stimulus(st_rd(BASE + 12, 0));
    check_output("timeout_instret", {48'd0, bus.mem_rdata}, {48'd0, 32'(retired)});
    apply_stimulus(st_rd(BASE + 8, 0));
    check_output("timeout_cycle", {48'd0, bus.mem_rdata}, {48'd0, 32'd49});

    // Reset pulse while halted.
    apply_stimulus(st_rst());
    check_output("reset_in_halted", dut_vec(), 80'd0);
    repeat (3) apply_stimulus(st_idle(0));
    apply_stimulus(st_rd(BASE + 8, 0));
    check_output("restart_cycle", {48'd0, bus.mem_rdata}, {48'd0, 32'd3});

    // Randomized traffic against the model.
    for (int run = 0; run < 6; run++) begin
      apply_stimulus(st_rst());
      check_output($sformatf("rand_reset_%0d", run), dut_vec(), model_vec());
      for (int c = 0; c < 70; c++) begin
        s = st_idle($urandom_range(0, 1));
        case ($urandom_range(0, 8))
          0, 1:    s.addr = BASE;
          2, 3, 4: s.addr = BASE + 4;
          5:       s.addr = BASE + 8;
          6:       s.addr = BASE + 12;
          7:       s.addr = BASE + 16;
          default: s.addr = $urandom;
        endcase
        s.we = ($urandom_range(0, 2) == 0);
        s.re = !s.we && ($urandom_range(0, 2) == 0);
        if (s.addr == BASE && $urandom_range(0, 9) != 0) s.wdata = $urandom & 32'hffff_fffe;
        else if ($urandom_range(0, 1) == 1)               s.wdata = 32'd1;
        else                                              s.wdata = $urandom;
        s.wbv = $urandom_range(0, 1);
        s.pc  = ($urandom_range(0, 39) == 0) ? HALT : $urandom;
        apply_stimulus(s);
        check_output($sformatf("rand_%0d_cycle_%0d", run, c), dut_vec(), model_vec());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
